// File: rtl/modexp_arbiter_if.sv
// modexp_arbiter_if: bundles the two requester ports and the shared engine port of
// modexp_arbiter.
//   slave  modport : the arbiter's view. It takes req, the operands, eng_result and
//                    eng_finish, and drives done, result, grant, busy, overrun,
//                    eng_start and eng_*.
//   master modport : the environment's view (requesters plus the engine), with the
//                    directions reversed.
// All operands and results are 2*WIDTH bits wide.
interface modexp_arbiter_if #(
  parameter int unsigned WIDTH = 8
) ();
  // Requester side
  logic [1:0]         req;
  logic [2*WIDTH-1:0] base0;
  logic [2*WIDTH-1:0] exp0;
  logic [2*WIDTH-1:0] mod0;
  logic [2*WIDTH-1:0] base1;
  logic [2*WIDTH-1:0] exp1;
  logic [2*WIDTH-1:0] mod1;
  logic [1:0]         done;
  logic [2*WIDTH-1:0] result;
  logic [1:0]         grant;
  logic               busy;
  logic               overrun;
  // Engine side
  logic               eng_start;
  logic [2*WIDTH-1:0] eng_base;
  logic [2*WIDTH-1:0] eng_exp;
  logic [2*WIDTH-1:0] eng_mod;
  logic [2*WIDTH-1:0] eng_result;
  logic               eng_finish;

  modport slave (
    input  req, base0, exp0, mod0, base1, exp1, mod1, eng_result, eng_finish,
    output done, result, grant, busy, overrun, eng_start, eng_base, eng_exp, eng_mod
  );

  modport master (
    output req, base0, exp0, mod0, base1, exp1, mod1, eng_result, eng_finish,
    input  done, result, grant, busy, overrun, eng_start, eng_base, eng_exp, eng_mod
  );
endinterface

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: shares one modular-exponentiation engine between two requesters.
// Port 0 is the encrypt path and port 1 is the decrypt path.
//
// The arbiter picks a winner round-robin in IDLE and latches that port's operands.
// It pulses eng_start, waits for eng_finish, and returns the result with a one-cycle
// done pulse to the winner.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : modexp_arbiter_if.slave, which carries the req/operands/done/result/grant/
//           busy/overrun requester signals and the eng_* engine signals
//
// Optional feature, macro CT_PAD_EN:
//   Adds a PAD state and a CNT_W-bit counter. done then lands exactly PAD_CYCLES+1
//   cycles after eng_start, whatever the exponent. The sticky overrun flag flags an
//   engine that ran too long. With the macro undefined, overrun is tied to 0.
module modexp_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PAD_CYCLES = 600,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  modexp_arbiter_if.slave bus
);
  localparam int unsigned DW = 2 * WIDTH;

`ifdef CT_PAD_EN
  typedef enum logic [2:0] {StIdle, StLaunch, StBusy, StPad, StDone} state_e;
  localparam logic [CNT_W-1:0] PadLast = CNT_W'(PAD_CYCLES - 1);
`else
  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} state_e;
`endif

  state_e        r_state;
  state_e        w_state_next;
  logic          r_owner;
  logic          r_last_owner;
  logic [DW-1:0] r_base;
  logic [DW-1:0] r_exp;
  logic [DW-1:0] r_mod;
  logic [DW-1:0] r_result;
  logic          w_winner;
  logic          w_capture;
  logic          w_set_overrun;

  // On a tie, the port that was not served last wins.
  assign w_winner = (bus.req == 2'b11) ? ~r_last_owner : bus.req[1];

`ifdef CT_PAD_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_overrun;

  // Cycles since launch. It saturates so that a hung engine cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == StLaunch) begin
      r_cnt <= '0;
    end else if ((r_state == StBusy || r_state == StPad) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_set_overrun) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_set_overrun = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|bus.req) begin
          w_state_next = StLaunch;
        end
      end
      StLaunch: w_state_next = StBusy;
      StBusy: begin
        if (bus.eng_finish) begin
          w_capture = 1'b1;
`ifdef CT_PAD_EN
          if (r_cnt < PadLast) begin
            w_state_next = StPad;
          end else begin
            w_state_next  = StDone;
            w_set_overrun = 1'b1;
          end
`else
          w_state_next = StDone;
`endif
        end
      end
`ifdef CT_PAD_EN
      StPad: begin
        if (r_cnt >= PadLast) begin
          w_state_next = StDone;
        end
      end
`endif
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_base       <= '0;
      r_exp        <= '0;
      r_mod        <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && (|bus.req)) begin
        r_owner <= w_winner;
        r_base  <= w_winner ? bus.base1 : bus.base0;
        r_exp   <= w_winner ? bus.exp1  : bus.exp0;
        r_mod   <= w_winner ? bus.mod1  : bus.mod0;
      end
      if (w_capture) begin
        r_result <= bus.eng_result;
      end
      if (r_state == StDone) begin
        r_last_owner <= r_owner;
      end
    end
  end

  assign bus.busy      = (r_state != StIdle);
  assign bus.eng_start = (r_state == StLaunch);
  assign bus.grant     = bus.busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done      = (r_state == StDone) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.result    = r_result;
  assign bus.eng_base  = r_base;
  assign bus.eng_exp   = r_exp;
  assign bus.eng_mod   = r_mod;
endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed self-checking bench for modexp_arbiter (WIDTH=8, PAD_CYCLES=40).
module tb_modexp_arbiter;
  localparam int unsigned Pad = 40;

  logic        clk;
  logic        rst_n;
  logic        m_finish;
  logic        s_finish;
  logic [15:0] m_result;
  logic [15:0] s_result;
  bit          eng_en;
  int          eng_lat;
  int          checks;
  int          failures;
  int          cyc;

  modexp_arbiter_if #(.WIDTH(8)) bus ();

  modexp_arbiter #(
    .WIDTH     (8),
    .PAD_CYCLES(Pad),
    .CNT_W     (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.eng_finish = m_finish | s_finish;
  assign bus.eng_result = s_finish ? s_result : m_result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                         input logic [15:0] m);
    logic [31:0] r;
    logic [31:0] x;
    if (m == 16'd0) return 16'd0;
    r = 32'd1 % 32'(m);
    x = 32'(b) % 32'(m);
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % 32'(m);
      x = (x * x) % 32'(m);
    end
    return r[15:0];
  endfunction

  // Engine model: answers eng_lat cycles after eng_start, using the latched operands.
  initial begin
    logic [15:0] b;
    logic [15:0] e;
    logic [15:0] m;
    m_finish = 1'b0;
    m_result = 16'd0;
    forever begin
      @(negedge clk);
      if (eng_en && bus.eng_start) begin
        b = bus.eng_base;
        e = bus.eng_exp;
        m = bus.eng_mod;
        repeat (eng_lat) @(negedge clk);
        m_result = modexp(b, e, m);
        m_finish = 1'b1;
        @(negedge clk);
        m_finish = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected eng_start-to-done distance for an engine latency of lat cycles.
  function automatic int exp_lat(input int lat);
`ifdef CT_PAD_EN
    return (lat < int'(Pad)) ? int'(Pad) + 1 : lat + 1;
`else
    return lat + 1;
`endif
  endfunction

  task automatic wait_start(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.eng_start && n < 200);
    check_eq({tag, "_start_seen"}, 32'(bus.eng_start), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done == 2'b00 && n < 2000);
    check_eq({tag, "_done_seen"}, 32'(bus.done != 2'b00), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  g_exp [4];
    logic [15:0] r_exp [4];
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    s_finish  = 1'b0;
    s_result  = 16'd0;
    eng_en    = 1'b1;
    eng_lat   = 10;
    bus.req   = 2'b00;
    bus.base0 = 16'd0;
    bus.exp0  = 16'd0;
    bus.mod0  = 16'd0;
    bus.base1 = 16'd0;
    bus.exp1  = 16'd0;
    bus.mod1  = 16'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_start", 32'(bus.eng_start), 32'd0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_eng_base", 32'(bus.eng_base), 32'd0);
    check_eq("rst_eng_mod", 32'(bus.eng_mod), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on port 0: 5^3 mod 33 = 26
    bus.base0 = 16'd5;
    bus.exp0  = 16'd3;
    bus.mod0  = 16'd33;
    bus.req   = 2'b01;
    @(negedge clk);
    check_eq("t1_start", 32'(bus.eng_start), 32'd1);
    check_eq("t1_grant", 32'(bus.grant), 32'd1);
    check_eq("t1_eng_base", 32'(bus.eng_base), 32'd5);
    check_eq("t1_eng_exp", 32'(bus.eng_exp), 32'd3);
    check_eq("t1_eng_mod", 32'(bus.eng_mod), 32'd33);
    bus.base0 = 16'd99;  // must not disturb the running operation
    wait_done("t1", cyc);
    check_eq("t1_latency", 32'(cyc), 32'(exp_lat(10)));
    check_eq("t1_done", 32'(bus.done), 32'd1);
    check_eq("t1_result", 32'(bus.result), 32'd26);
    check_eq("t1_eng_base_held", 32'(bus.eng_base), 32'd5);
    bus.req = 2'b00;
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(bus.done), 32'd0);
    check_eq("t1_idle", 32'(bus.busy), 32'd0);

    // Simultaneous requests after reset: port 0 first (26), then port 1 (26^7 mod 33 = 5)
    do_reset();
    bus.base0 = 16'd5;
    bus.exp0  = 16'd3;
    bus.mod0  = 16'd33;
    bus.base1 = 16'd26;
    bus.exp1  = 16'd7;
    bus.mod1  = 16'd33;
    bus.req   = 2'b11;
    @(negedge clk);
    check_eq("t2_start0", 32'(bus.eng_start), 32'd1);
    check_eq("t2_grant0", 32'(bus.grant), 32'd1);
    check_eq("t2_eng_base0", 32'(bus.eng_base), 32'd5);
    wait_done("t2a", cyc);
    check_eq("t2_done0", 32'(bus.done), 32'd1);
    check_eq("t2_result0", 32'(bus.result), 32'd26);
    bus.req = 2'b10;
    @(negedge clk);
    check_eq("t2_gap_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("t2_start1", 32'(bus.eng_start), 32'd1);
    check_eq("t2_grant1", 32'(bus.grant), 32'd2);
    check_eq("t2_eng_base1", 32'(bus.eng_base), 32'd26);
    check_eq("t2_eng_exp1", 32'(bus.eng_exp), 32'd7);
    wait_done("t2b", cyc);
    check_eq("t2_done1", 32'(bus.done), 32'd2);
    check_eq("t2_result1", 32'(bus.result), 32'd5);
    bus.req = 2'b00;
    @(negedge clk);

    // Fairness with both requests held. Results: 7^2%10=9, 3^4%7=4, 2^10%1000=24, 9^5%11=1
    g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    r_exp = '{16'd9, 16'd4, 16'd24, 16'd1};
    eng_lat   = 4;
    bus.base0 = 16'd7;
    bus.exp0  = 16'd2;
    bus.mod0  = 16'd10;
    bus.base1 = 16'd3;
    bus.exp1  = 16'd4;
    bus.mod1  = 16'd7;
    bus.req   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("t3_%0d", i), cyc);
      check_eq($sformatf("t3_start_gap_%0d", i), 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
      check_eq($sformatf("t3_grant_%0d", i), 32'(bus.grant), 32'(g_exp[i]));
      wait_done($sformatf("t3_%0d", i), cyc);
      check_eq($sformatf("t3_done_%0d", i), 32'(bus.done), 32'(g_exp[i]));
      check_eq($sformatf("t3_result_%0d", i), 32'(bus.result), 32'(r_exp[i]));
      if (i == 0) begin
        bus.base0 = 16'd2;
        bus.exp0  = 16'd10;
        bus.mod0  = 16'd1000;
      end else if (i == 1) begin
        bus.base1 = 16'd9;
        bus.exp1  = 16'd5;
        bus.mod1  = 16'd11;
      end else if (i == 3) begin
        bus.req = 2'b00;
      end
    end
    repeat (2) @(negedge clk);

    // Stray eng_finish in IDLE
    s_result = 16'hABCD;
    s_finish = 1'b1;
    @(negedge clk);
    s_finish = 1'b0;
    check_eq("t4_done", 32'(bus.done), 32'd0);
    check_eq("t4_busy", 32'(bus.busy), 32'd0);
    check_eq("t4_result", 32'(bus.result), 32'd1);
    @(negedge clk);
    check_eq("t4_busy_later", 32'(bus.busy), 32'd0);
    check_eq("t4_result_later", 32'(bus.result), 32'd1);

    // Reset three cycles into BUSY, then a stale finish
    eng_en    = 1'b0;
    bus.base0 = 16'd5;
    bus.exp0  = 16'd3;
    bus.mod0  = 16'd33;
    bus.req   = 2'b01;
    wait_start("t5", cyc);
    @(negedge clk);
    check_eq("t5_start_pulse", 32'(bus.eng_start), 32'd0);
    check_eq("t5_busy", 32'(bus.busy), 32'd1);
    repeat (2) @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 2'b00;
    #1;
    check_eq("t5_async_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_async_grant", 32'(bus.grant), 32'd0);
    check_eq("t5_async_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_result = 16'h1234;
    s_finish = 1'b1;
    @(negedge clk);
    s_finish = 1'b0;
    check_eq("t5_stale_done", 32'(bus.done), 32'd0);
    check_eq("t5_stale_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_stale_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    check_eq("t5_stale_done2", 32'(bus.done), 32'd0);
    eng_en = 1'b1;

    // Lone port 1 request after reset: 3^4 mod 7 = 4
    bus.base1 = 16'd3;
    bus.exp1  = 16'd4;
    bus.mod1  = 16'd7;
    bus.req   = 2'b10;
    wait_start("t6", cyc);
    check_eq("t6_grant", 32'(bus.grant), 32'd2);
    wait_done("t6", cyc);
    check_eq("t6_done", 32'(bus.done), 32'd2);
    check_eq("t6_result", 32'(bus.result), 32'd4);
    bus.req = 2'b00;
    @(negedge clk);
    check_eq("t6_overrun", 32'(bus.overrun), 32'd0);

`ifdef CT_PAD_EN
    // Constant-time padding: lat 8 and 30 pad to 41, lat 50 overruns to 51
    begin
      int lats [4];
      lats = '{8, 30, 50, 8};
      do_reset();
      bus.base0 = 16'd5;
      bus.exp0  = 16'd3;
      bus.mod0  = 16'd33;
      for (int i = 0; i < 4; i++) begin
        eng_lat = lats[i];
        bus.req = 2'b01;
        wait_start($sformatf("t7_%0d", i), cyc);
        wait_done($sformatf("t7_%0d", i), cyc);
        bus.req = 2'b00;
        check_eq($sformatf("t7_latency_%0d", i), 32'(cyc), (i == 2) ? 32'd51 : 32'd41);
        check_eq($sformatf("t7_result_%0d", i), 32'(bus.result), 32'd26);
        check_eq($sformatf("t7_overrun_%0d", i), 32'(bus.overrun), (i >= 2) ? 32'd1 : 32'd0);
        repeat (2) @(negedge clk);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modexp_arbiter.md
Name: modexp_arbiter

Overview:
- Shares one modular-exponentiation engine (result = base^exp mod n) between two requesters: port 0 (encrypt path) and port 1 (decrypt path).
- Arbitrates round-robin, latches the winner's operands, and pulses the engine start.
- Waits for the engine finish, then returns the result with a one-cycle done pulse to the winner.
- Sits between the encrypt/decrypt control logic and a single shared square-and-multiply engine, replacing two dedicated engines.

Parameters:
- WIDTH, 8, prime width; all operands and the result are 2*WIDTH bits.
- PAD_CYCLES, 600, fixed engine-window length in cycles; used only when CT_PAD_EN is defined.
- CNT_W, 16, pad counter width; must satisfy PAD_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-port request; held high until that port's done pulse
- base0, exp0, mod0  in  2*WIDTH each  port 0 operands
- base1, exp1, mod1  in  2*WIDTH each  port 1 operands
- done  out  2  per-port one-cycle completion pulse
- result  out  2*WIDTH  last completed result; valid when any done bit is high, held otherwise
- grant  out  2  one-hot owner of the engine, high from LAUNCH through DONE
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky; engine exceeded PAD_CYCLES (CT_PAD_EN only, else tied 0)
- eng_start  out  1  one-cycle engine start pulse
- eng_base, eng_exp, eng_mod  out  2*WIDTH each  latched operands, stable from LAUNCH until the next LAUNCH
- eng_result  in  2*WIDTH  engine result, valid with eng_finish
- eng_finish  in  1  one-cycle engine completion pulse

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; done, grant, busy, overrun, eng_start = 0.
  - result and all eng_* operand registers = 0.
  - last_owner = 1, so port 0 wins the first tie.
- FSM states:
  - IDLE: if any req bit is high, select the winner and register its operands into the eng_* registers. Go to LAUNCH next cycle.
  - LAUNCH: eng_start=1 for exactly one cycle; grant is one-hot. Go to BUSY.
  - BUSY: wait for eng_finish. On eng_finish, capture eng_result into result and go to DONE (or PAD, see Optional Feature).
  - DONE: done[owner]=1 for one cycle; last_owner := owner. Go to IDLE.
- Arbitration:
  - Only one request: that port wins.
  - Both requests: the port != last_owner wins.
  - req is sampled only in IDLE.
  - A req that drops before it is granted is lost without error.
- Latency:
  - req rising with the FSM in IDLE (cycle T): eng_start at T+1.
  - eng_finish at cycle F: done at F+1.
  - Minimum IDLE-to-next-grant gap is 1 cycle (DONE→IDLE).
- Requester rules:
  - The requester deasserts req in the cycle after its done pulse.
  - If it does not deassert, the port re-requests; round-robin still favours the other port if both are high.
- eng_finish is ignored in IDLE, LAUNCH and DONE. A stray pulse causes no state change.
- Operand changes on base*/exp*/mod* after latching have no effect on the running operation.
- Reset mid-operation: the FSM returns to IDLE immediately and the engine is abandoned. A later stale eng_finish is ignored. The engine has its own rst_n.
- exp=0 and mod=1 are passed through unchecked; correctness is the engine's responsibility.

Optional Feature:
- Macro: CT_PAD_EN (timing side-channel hardening).
- Defined:
  - An added PAD state and a CNT_W counter. The counter clears at LAUNCH and increments every cycle in BUSY and PAD.
  - On eng_finish, result is captured. If count < PAD_CYCLES-1, go to PAD. Otherwise go to DONE and set overrun sticky (cleared only by reset).
  - PAD → DONE when count reaches PAD_CYCLES-1.
  - done therefore occurs exactly PAD_CYCLES+1 cycles after eng_start, independent of exponent value.
- Undefined: no PAD state, no counter; overrun tied 0; done follows eng_finish by 1 cycle.

Test Plan:
- Single request: req=2'b01, base0=5, exp0=3, mod0=33. Expect eng_start 1 cycle after req, grant=01. Engine model finishes after 10 cycles; expect done=01 one cycle later, result=26.
- Simultaneous requests after reset: port0 (5,3,33) and port1 (26,7,33). Expect port0 served first (result 26), then port1 (result 5), done pulses in that order.
- Fairness: both req held high across 4 operations. Expect grant to alternate 01,10,01,10. No port is granted twice in a row while the other is requesting.
- Reset mid-BUSY: assert rst_n low 3 cycles after eng_start, release, then pulse eng_finish. Expect state IDLE, no done, result=0, busy=0.
- CT_PAD_EN, PAD_CYCLES=40: engine finishes at 8 and at 30 cycles. Expect done exactly 41 cycles after eng_start in both cases, overrun=0. Engine finishing at 50 cycles: done at 51 cycles after eng_start, overrun=1 and held.
- Stray eng_finish pulsed in IDLE: expect no done, no state change, result unchanged.
